// File: rtl/cfg_pkg.sv
// cfg_pkg: system-wide width configuration shared by the hash table and
// its command initiator.
//   K_W - key width
//   V_W - value width
//   H_W - hash width supplied by the initiator with every command
package cfg_pkg;

  localparam int K_W = 8;
  localparam int V_W = 8;
  localparam int H_W = 8;

endpackage

// File: rtl/h_pkg.sv
// h_pkg: types for the hash-table command interface (opcodes, status codes,
// key/value/hash types), the table slot record and the responder FSM states.
package h_pkg;

  localparam int OPCODE_W = 2;
  localparam int STATUS_W = 3;

  typedef logic [cfg_pkg::K_W-1:0] k_t;
  typedef logic [cfg_pkg::V_W-1:0] v_t;
  typedef logic [cfg_pkg::H_W-1:0] h_t;

  // Encoding 2'd3 is deliberately unassigned; the responder answers it with
  // NOTFOUND and leaves the table untouched.
  typedef enum logic [OPCODE_W-1:0] {
    OP_INSERT = 2'd0,
    OP_FIND   = 2'd1,
    OP_CLEAR  = 2'd2
  } opcode_t;

  typedef enum logic [STATUS_W-1:0] {
    STATUS_SUCCESS  = 3'b000,
    STATUS_FULL     = 3'b001,
    STATUS_NOTFOUND = 3'b010
  } status_t;

  typedef struct packed {
    logic valid;
    k_t   key;
    v_t   value;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PROBE,
    ST_RESP
  } h_tbl_state_t;

endpackage

// File: rtl/h_tbl_store.sv
// h_tbl_store: slot array of the hash table.
//   clk, arst  - clock, async active-high reset (clears valid bits only)
//   clr        - single-cycle clear of every valid bit
//   rd_idx     - combinational read index, rd_slot is the slot contents
//   wr_en      - write wr_key/wr_value into slot wr_idx and mark it valid
module h_tbl_store
  import h_pkg::*;
#(
  parameter int ENTRIES_N = 16,
  localparam int IDX_W = $clog2(ENTRIES_N)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             clr,
  input  logic [IDX_W-1:0] rd_idx,
  output slot_t            rd_slot,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  k_t               wr_key,
  input  v_t               wr_value
);

  logic [ENTRIES_N-1:0] valid_q;
  k_t                   key_q   [ENTRIES_N];
  v_t                   value_q [ENTRIES_N];

  // Only the valid bits carry reset; an invalid slot's key/value is never read
  // as meaningful, so the payload storage stays reset-free.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q <= '0;
    end else if (clr) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_q[wr_idx]   <= wr_key;
      value_q[wr_idx] <= wr_value;
    end
  end

  always_comb begin
    rd_slot.valid = valid_q[rd_idx];
    rd_slot.key   = key_q[rd_idx];
    rd_slot.value = value_q[rd_idx];
  end

endmodule

// File: rtl/h_tbl.sv
// h_tbl: responder end of the hash-table command interface. Open addressing
// with linear probing, one slot examined per cycle, one command in flight.
//   clk, arst          - clock, async active-high reset
//   cmd_vld/cmd_rdy    - command handshake (cmd_rdy high only in IDLE)
//   cmd_opcode/key/value/hash - command payload; home slot = low hash bits
//   rsp_vld/rsp_rdy    - response handshake
//   rsp_opcode/status/value - response payload, held until consumed
module h_tbl
  import h_pkg::*;
#(
  parameter int ENTRIES_N = 16
) (
  input  logic    clk,
  input  logic    arst,
  input  logic    cmd_vld,
  output logic    cmd_rdy,
  input  opcode_t cmd_opcode,
  input  k_t      cmd_key,
  input  v_t      cmd_value,
  input  h_t      cmd_hash,
  output logic    rsp_vld,
  input  logic    rsp_rdy,
  output opcode_t rsp_opcode,
  output status_t rsp_status,
  output v_t      rsp_value
);

  localparam int IDX_W = $clog2(ENTRIES_N);

  h_tbl_state_t     state_q, state_d;
  opcode_t          op_q;
  k_t               key_q;
  v_t               value_q;
  logic [IDX_W-1:0] home_q, cnt_q, probe_idx;
  slot_t            cur;
  logic             accept, hit, last_probe, resolve, store_wr, store_clr;
  status_t          probe_status;
  v_t               probe_value;

  if (IDX_W < cfg_pkg::H_W) begin : g_hash_hi
    logic unused_hash_hi;
    assign unused_hash_hi = ^cmd_hash[cfg_pkg::H_W-1:IDX_W];
  end

  // Wrap-around past the last slot falls out of the IDX_W-bit truncation.
  assign probe_idx  = home_q + cnt_q;
  assign accept     = cmd_vld & cmd_rdy;
  assign hit        = cur.valid && (cur.key == key_q);
  assign last_probe = (cnt_q == IDX_W'(ENTRIES_N - 1));
  assign resolve    = !cur.valid || hit || last_probe;
  assign store_wr   = (state_q == ST_PROBE) && (op_q == OP_INSERT) && !cur.valid;
  assign store_clr  = accept && (cmd_opcode == OP_CLEAR);

  h_tbl_store #(.ENTRIES_N(ENTRIES_N)) u_store (
    .clk      (clk),
    .arst     (arst),
    .clr      (store_clr),
    .rd_idx   (probe_idx),
    .rd_slot  (cur),
    .wr_en    (store_wr),
    .wr_idx   (probe_idx),
    .wr_key   (key_q),
    .wr_value (value_q)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_opcode == OP_INSERT || cmd_opcode == OP_FIND) state_d = ST_PROBE;
          else                                                  state_d = ST_RESP;
        end
      end
      ST_PROBE: if (resolve) state_d = ST_RESP;
      ST_RESP:  if (rsp_rdy) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // rsp_vld is a pure decode of the state register, so it has no path from
  // any input.
  always_comb begin
    cmd_rdy = (state_q == ST_IDLE);
    rsp_vld = (state_q == ST_RESP);
  end

  // Outcome of the slot under examination. A miss on the final slot of a full
  // chain means FULL for INSERT and NOTFOUND for FIND. An INSERT hit returns
  // the stored value and leaves the table alone.
  always_comb begin
    probe_status = STATUS_NOTFOUND;
    probe_value  = '0;
    if (hit) begin
      probe_status = STATUS_SUCCESS;
      probe_value  = cur.value;
    end else if (!cur.valid) begin
      if (op_q == OP_INSERT) begin
        probe_status = STATUS_SUCCESS;
        probe_value  = value_q;
      end
    end else if (op_q == OP_INSERT) begin
      probe_status = STATUS_FULL;
    end
  end

  // Command latch, probe counter and response registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      op_q       <= OP_INSERT;
      key_q      <= '0;
      value_q    <= '0;
      home_q     <= '0;
      cnt_q      <= '0;
      rsp_opcode <= opcode_t'('0);
      rsp_status <= status_t'('0);
      rsp_value  <= '0;
    end else begin
      if (accept) begin
        op_q       <= cmd_opcode;
        key_q      <= cmd_key;
        value_q    <= cmd_value;
        home_q     <= cmd_hash[IDX_W-1:0];
        cnt_q      <= '0;
        rsp_opcode <= cmd_opcode;
        rsp_value  <= '0;
        if (cmd_opcode == OP_CLEAR) rsp_status <= STATUS_SUCCESS;
        else                        rsp_status <= STATUS_NOTFOUND;
      end else if (state_q == ST_PROBE) begin
        if (resolve) begin
          rsp_status <= probe_status;
          rsp_value  <= probe_value;
        end else begin
          cnt_q <= cnt_q + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_h_tbl.sv
// tb_h_tbl: directed-vector bench for h_tbl with a response scoreboard.
// Commands push their hand-computed response and latency into a queue; a
// negedge monitor pops and compares whenever a new response appears.
module tb_h_tbl;
  import h_pkg::*;

  logic    clk = 1'b0;
  logic    arst;
  logic    cmd_vld;
  logic    cmd_rdy;
  opcode_t cmd_opcode;
  k_t      cmd_key;
  v_t      cmd_value;
  h_t      cmd_hash;
  logic    rsp_vld;
  logic    rsp_rdy;
  opcode_t rsp_opcode;
  status_t rsp_status;
  v_t      rsp_value;

  always #5 clk = ~clk;

  h_tbl #(.ENTRIES_N(16)) dut (
    .clk        (clk),
    .arst       (arst),
    .cmd_vld    (cmd_vld),
    .cmd_rdy    (cmd_rdy),
    .cmd_opcode (cmd_opcode),
    .cmd_key    (cmd_key),
    .cmd_value  (cmd_value),
    .cmd_hash   (cmd_hash),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_opcode (rsp_opcode),
    .rsp_status (rsp_status),
    .rsp_value  (rsp_value)
  );

  typedef struct {
    opcode_t op;
    status_t st;
    v_t      val;
    int      lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cycle = 0;
  int   accept_cycle = 0;
  bit   rsp_checked = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: latency is counted from the cycle the handshake was
  // seen to the first cycle the response is visible.
  always @(negedge clk) begin
    cycle++;
    if (arst) begin
      rsp_checked = 1'b0;
    end else begin
      if (cmd_vld && cmd_rdy) accept_cycle = cycle;
      if (rsp_vld && !rsp_checked) begin
        rsp_checked = 1'b1;
        if (sb_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_rsp: got status 0x%0h value 0x%0h expected no response",
                   rsp_status, rsp_value);
        end else begin
          mon_e = sb_q.pop_front();
          check_output("rsp_opcode", rsp_opcode, mon_e.op);
          check_output("rsp_status", rsp_status, mon_e.st);
          check_output("rsp_value", rsp_value, mon_e.val);
          check_output("latency", cycle - accept_cycle, mon_e.lat);
        end
      end
      if (rsp_vld && rsp_rdy) rsp_checked = 1'b0;
    end
  end

  task automatic apply_stimulus(input opcode_t op, input k_t key, input v_t val, input h_t hash,
                                input status_t est, input v_t evl, input int elat);
    int n;
    exp_t e;
    @(posedge clk); #1;
    n = 0;
    while (!cmd_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_rdy) begin
      check_output("cmd_rdy_timeout", cmd_rdy, 1);
      return;
    end
    e.op = op; e.st = est; e.val = evl; e.lat = elat;
    sb_q.push_back(e);
    cmd_vld = 1'b1; cmd_opcode = op; cmd_key = key; cmd_value = val; cmd_hash = hash;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check_output("rsp_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    arst = 1'b1; cmd_vld = 1'b0; rsp_rdy = 1'b1;
    cmd_opcode = OP_INSERT; cmd_key = '0; cmd_value = '0; cmd_hash = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_rsp_vld", rsp_vld, 0);
    check_output("reset_rsp_opcode", rsp_opcode, 0);
    check_output("reset_rsp_status", rsp_status, 0);
    check_output("reset_rsp_value", rsp_value, 0);
    arst = 1'b0;
    @(posedge clk); #1;
    check_output("reset_cmd_rdy", cmd_rdy, 1);

    // Insert, find, duplicate insert keeps the original value
    apply_stimulus(OP_INSERT, 8'h05, 8'hAA, 8'h03, STATUS_SUCCESS, 8'hAA, 2);
    apply_stimulus(OP_FIND,   8'h05, 8'h00, 8'h03, STATUS_SUCCESS, 8'hAA, 2);
    apply_stimulus(OP_INSERT, 8'h05, 8'hBB, 8'h03, STATUS_SUCCESS, 8'hAA, 2);
    apply_stimulus(OP_FIND,   8'h05, 8'h00, 8'h03, STATUS_SUCCESS, 8'hAA, 2);

    // Collision chain wrapping from slot 15 to slots 0 and 1
    apply_stimulus(OP_INSERT, 8'h01, 8'h10, 8'h0F, STATUS_SUCCESS, 8'h10, 2);
    apply_stimulus(OP_INSERT, 8'h02, 8'h20, 8'h0F, STATUS_SUCCESS, 8'h20, 3);
    apply_stimulus(OP_INSERT, 8'h03, 8'h30, 8'h0F, STATUS_SUCCESS, 8'h30, 4);
    apply_stimulus(OP_FIND,   8'h03, 8'h00, 8'h0F, STATUS_SUCCESS, 8'h30, 4);
    apply_stimulus(OP_FIND,   8'h09, 8'h00, 8'h0F, STATUS_NOTFOUND, 8'h00, 5);
    apply_stimulus(OP_FIND,   8'h02, 8'h00, 8'hFF, STATUS_SUCCESS, 8'h20, 3);

    // Unassigned opcode
    apply_stimulus(opcode_t'(2'd3), 8'h05, 8'h00, 8'h03, STATUS_NOTFOUND, 8'h00, 1);

    // Reset during the third probe cycle of a FIND
    @(posedge clk); #1;
    check_output("pre_abort_cmd_rdy", cmd_rdy, 1);
    cmd_vld = 1'b1; cmd_opcode = OP_FIND; cmd_key = 8'h09; cmd_hash = 8'h0F;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    arst = 1'b1;
    #1;
    check_output("abort_rsp_vld", rsp_vld, 0);
    @(posedge clk); #1;
    arst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check_output("abort_no_rsp", rsp_vld, 0);
    end
    check_output("abort_cmd_rdy", cmd_rdy, 1);
    apply_stimulus(OP_FIND, 8'h05, 8'h00, 8'h03, STATUS_NOTFOUND, 8'h00, 2);
    apply_stimulus(OP_FIND, 8'h01, 8'h00, 8'h0F, STATUS_NOTFOUND, 8'h00, 2);
    apply_stimulus(OP_FIND, 8'h03, 8'h00, 8'h0F, STATUS_NOTFOUND, 8'h00, 2);

    // Fill every slot, then overflow
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(OP_INSERT, k_t'(8'h10 + i), v_t'(8'h80 + i), h_t'(i),
                     STATUS_SUCCESS, v_t'(8'h80 + i), 2);
    end
    apply_stimulus(OP_FIND,   8'h1A, 8'h00, 8'h05, STATUS_SUCCESS, 8'h8A, 7);
    apply_stimulus(OP_INSERT, 8'h40, 8'h55, 8'h07, STATUS_FULL, 8'h00, 17);
    apply_stimulus(OP_FIND,   8'h40, 8'h00, 8'h07, STATUS_NOTFOUND, 8'h00, 17);

    // CLEAR under response backpressure
    rsp_rdy = 1'b0;
    apply_stimulus(OP_CLEAR, 8'h00, 8'h00, 8'h00, STATUS_SUCCESS, 8'h00, 1);
    repeat (5) begin
      @(negedge clk);
      check_output("hold_rsp_vld", rsp_vld, 1);
      check_output("hold_cmd_rdy", cmd_rdy, 0);
      check_output("hold_rsp_opcode", rsp_opcode, OP_CLEAR);
      check_output("hold_rsp_status", rsp_status, STATUS_SUCCESS);
      check_output("hold_rsp_value", rsp_value, 0);
    end
    @(posedge clk); #1;
    rsp_rdy = 1'b1;
    apply_stimulus(OP_FIND, 8'h13, 8'h00, 8'h03, STATUS_NOTFOUND, 8'h00, 2);
    apply_stimulus(OP_FIND, 8'h1F, 8'h00, 8'h0F, STATUS_NOTFOUND, 8'h00, 2);
    apply_stimulus(OP_INSERT, 8'h13, 8'h77, 8'h03, STATUS_SUCCESS, 8'h77, 2);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/h_tbl.md
Name: h_tbl

Overview:
- Responder end of the h_pkg command interface: accepts INSERT/FIND/CLEAR commands and returns one status/value response per command.
- Implements a hash table of ENTRIES_N slots in flops, using open addressing with linear probing.
- The initiator supplies a precomputed hash with each command.
- Sits behind the command initiator; one command is in flight at a time.

Parameters:
- ENTRIES_N, 16, table slot count; power of 2, ≥2, ≤2**cfg_pkg::H_W.
- IDX_W, $clog2(ENTRIES_N), slot index width; localparam, not overridable.

Ports:
- clk  in  1  single clock; all state on posedge.
- arst  in  1  asynchronous, active-high reset.
- cmd_vld  in  1  command valid.
- cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy.
- cmd_opcode  in  h_pkg::OPCODE_W  h_pkg::opcode_t.
- cmd_key  in  cfg_pkg::K_W  key (h_pkg::k_t).
- cmd_value  in  cfg_pkg::V_W  insert value (h_pkg::v_t); ignored for other opcodes.
- cmd_hash  in  cfg_pkg::H_W  key hash (h_pkg::h_t); home slot = cmd_hash[IDX_W-1:0].
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response consumed when rsp_vld & rsp_rdy.
- rsp_opcode  out  h_pkg::OPCODE_W  echo of the accepted opcode.
- rsp_status  out  h_pkg::STATUS_W  h_pkg::status_t.
- rsp_value  out  cfg_pkg::V_W  result value.

Behaviour:
- Reset (async assert):
  - state=IDLE; all slot valid bits=0.
  - rsp_vld=0; rsp_opcode/rsp_status/rsp_value=0.
  - Key/value storage is not reset.
  - cmd_rdy=1 from the first cycle after reset deassert.
- FSM states: IDLE, PROBE, RESP.
- cmd_rdy = (state==IDLE), combinational from state only.
- IDLE, command accepted in cycle T:
  - Latch opcode, key, value, and home index.
  - Probe counter=0.
  - INSERT/FIND go to PROBE.
  - CLEAR zeroes all valid bits at the edge ending T, goes to RESP; rsp_status=SUCCESS, rsp_value=0.
  - Unlisted opcode: go to RESP with NOTFOUND, value 0, no table change.
- PROBE: one slot per cycle.
  - Slot index = (home + cnt) mod ENTRIES_N; wrap-around comes from IDX_W truncation.
  - Probe k (k=0..ENTRIES_N-1) occurs in cycle T+1+k; rsp_vld rises in cycle T+2+k.
  - Slot valid & key match:
    - FIND: SUCCESS, rsp_value = stored value.
    - INSERT: SUCCESS, rsp_value = stored value. The table is NOT modified (unordered_map::insert semantics).
  - Slot invalid:
    - FIND: NOTFOUND, value 0.
    - INSERT: write key/value and set valid at this edge; SUCCESS, rsp_value = cmd_value.
  - Otherwise cnt++. If cnt==ENTRIES_N-1 (last slot examined, no resolution):
    - FIND: NOTFOUND, value 0.
    - INSERT: STATUS_FULL, value 0, no write.
  - There is no delete, so the probe chain terminates at the first invalid slot; no tombstones.
- RESP:
  - rsp_vld=1; rsp fields held stable until rsp_vld & rsp_rdy, then go to IDLE.
  - A new command can be accepted one cycle after the handshake.
  - rsp_vld is registered and has no combinational path from cmd_* or rsp_rdy.
- Latency, accept to rsp_vld:
  - CLEAR or illegal opcode: 1 cycle.
  - Hit or miss at probe k: k+2 cycles.
  - Worst case: ENTRIES_N+1 cycles.
- Simultaneous events: none possible; commands are serialized by cmd_rdy. A write and a response never conflict because the write happens on the PROBE→RESP edge.
- Reset mid-PROBE or mid-RESP: the operation is aborted and its response lost; the table is empty afterwards. No partial write is possible because the write is a single edge.
- Invariants:
  - At most one response per accepted command, in order.
  - rsp_opcode equals the accepted opcode.

Decomposition:
- h_pkg additions:
  - STATUS_FULL = 3'b001.
  - Slot struct {valid, k_t key, v_t value}.
  - FSM state enum h_tbl_state_t.
- Sub-module h_tbl_store:
  - ENTRIES_N slot array.
  - One combinational read port by index.
  - One write port.
  - Single-cycle clear of all valid bits.
- The FSM, counter and response registers stay in h_tbl.

Test Plan:
- Insert/find: INSERT key=0x5, hash=0x3, value=0xAA; rsp_rdy=1 → SUCCESS, value 0xAA, rsp_vld 2 cycles after accept. Then FIND key=0x5, hash=0x3 → SUCCESS, value 0xAA.
- Duplicate insert: INSERT key=0x5, hash=0x3, value=0xBB → SUCCESS, value 0xAA. A following FIND returns 0xAA (no overwrite).
- Collision and wrap, ENTRIES_N=16: INSERT keys 1,2,3, all with hash=0xF.
  - Keys land in slots 15, 0, 1.
  - FIND key 3 → SUCCESS at latency 4.
  - FIND key 9, hash 0xF → NOTFOUND at latency 5 (stops at empty slot 2).
- Full table: fill 16 distinct keys, then INSERT a new key → STATUS_FULL at latency 17. FIND of that key → NOTFOUND at latency 17.
- CLEAR and backpressure:
  - CLEAR → SUCCESS at latency 1.
  - Hold rsp_rdy=0 for 5 cycles: rsp fields stable and cmd_rdy=0 throughout.
  - Then FIND of any prior key → NOTFOUND at latency 2.
- Reset mid-probe: assert arst during the 3rd PROBE cycle of a FIND.
  - rsp_vld=0 immediately; no response emitted.
  - cmd_rdy=1 after deassert.
  - All prior keys → NOTFOUND.
